tank_access_sequencer: RTL and testbench

//  Sequences one word transfer into/out of a mercury-delay-line tank group (4 tanks, r2 down side).

---
 rtl/edsac_tank_pkg.sv | 25 ++
 rtl/tank_timing_counter.sv | 46 ++++
 rtl/tank_access_sequencer.sv | 127 ++++++++++++
 tb/tb_tank_access_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_tank_pkg.sv
// Shared constants, request payload and FSM encoding for the tank-group access sequencers.
package edsac_tank_pkg;

    localparam int unsigned DIGITS_PER_MINOR = 18;
    localparam int unsigned DATA_DIGITS      = 17;
    localparam int unsigned WORDS_PER_TANK   = 32;
    localparam int unsigned WORD_W           = 5;
    localparam int unsigned DIGIT_W          = 5;
    localparam int unsigned TANK_W           = 2;
    localparam int unsigned ADDR_W           = TANK_W + WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_XFER      = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              write;
        logic [TANK_W-1:0] tank;
        logic [WORD_W-1:0] word;
    } tank_req_t;

endpackage

// File: rtl/tank_timing_counter.sv
// Free-running digit/minor-cycle position of the circulating tank contents.
// Also exposes the next-state positions so the sequencer can act on the same edge.
module tank_timing_counter
    import edsac_tank_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_tick,
    output logic [DIGIT_W-1:0] digit_pos,
    output logic [WORD_W-1:0]  minor_pos,
    output logic               wrap_c,
    output logic [DIGIT_W-1:0] digit_nxt_c,
    output logic [WORD_W-1:0]  minor_nxt_c
);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [WORD_W-1:0]  minor_q, minor_d;

    always_comb begin
        digit_d = digit_q;
        minor_d = minor_q;
        wrap_c  = digit_tick && (digit_q == DIGIT_W'(DIGITS_PER_MINOR - 1));
        if (digit_tick) begin
            digit_d = wrap_c ? '0 : digit_q + DIGIT_W'(1);
        end
        if (wrap_c) begin
            minor_d = (minor_q == WORD_W'(WORDS_PER_TANK - 1)) ? '0 : minor_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            minor_q <= '0;
        end else begin
            digit_q <= digit_d;
            minor_q <= minor_d;
        end
    end

    assign digit_pos   = digit_q;
    assign minor_pos   = minor_q;
    assign digit_nxt_c = digit_d;
    assign minor_nxt_c = minor_d;

endmodule

// File: rtl/tank_access_sequencer.sv
// Single-word transfer sequencer for a 4-tank delay-line group: waits for the addressed
// word slot, then drives tank select and the in/out gate for that word's data digits.
module tank_access_sequencer
    import edsac_tank_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_tick,
    input  logic               req,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               f7_pos,
    output logic               f7_neg,
    output logic               f8_pos,
    output logic               f8_neg,
    output logic               t_in,
    output logic               t_out,
    output logic [DIGIT_W-1:0] digit_pos,
    output logic [WORD_W-1:0]  minor_pos
);

    logic               wrap_c;
    logic [DIGIT_W-1:0] digit_nxt_c;
    logic [WORD_W-1:0]  minor_nxt_c;

    tank_timing_counter u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_tick  (digit_tick),
        .digit_pos   (digit_pos),
        .minor_pos   (minor_pos),
        .wrap_c      (wrap_c),
        .digit_nxt_c (digit_nxt_c),
        .minor_nxt_c (minor_nxt_c)
    );

    seq_state_e state_q, state_d;
    tank_req_t  req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       f7_pos_q, f7_pos_d, f7_neg_q, f7_neg_d;
    logic       f8_pos_q, f8_pos_d, f8_neg_q, f8_neg_d;
    logic       t_in_q, t_in_d, t_out_q, t_out_d;
    logic       active_c, gate_c;

    // Outputs are decoded from next state/position so they change on the same edge as the counters.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_WAIT_SLOT;
                    req_d.write = req_write;
                    req_d.tank  = req_addr[ADDR_W-1:WORD_W];
                    req_d.word  = req_addr[WORD_W-1:0];
                end
            end
            ST_WAIT_SLOT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wrap_c && (minor_nxt_c == req_q.word)) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (digit_tick && (digit_pos == DIGIT_W'(DATA_DIGITS - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        active_c = (state_d != ST_IDLE);
        gate_c   = (state_d == ST_XFER) && (digit_nxt_c < DIGIT_W'(DATA_DIGITS));
        busy_d   = active_c;
        done_d   = (state_d == ST_DONE);
        f7_pos_d = active_c &&  req_d.tank[0];
        f7_neg_d = active_c && !req_d.tank[0];
        f8_pos_d = active_c &&  req_d.tank[1];
        f8_neg_d = active_c && !req_d.tank[1];
        t_in_d   = gate_c &&  req_d.write;
        t_out_d  = gate_c && !req_d.write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            f7_pos_q <= 1'b0;
            f7_neg_q <= 1'b0;
            f8_pos_q <= 1'b0;
            f8_neg_q <= 1'b0;
            t_in_q   <= 1'b0;
            t_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            f7_pos_q <= f7_pos_d;
            f7_neg_q <= f7_neg_d;
            f8_pos_q <= f8_pos_d;
            f8_neg_q <= f8_neg_d;
            t_in_q   <= t_in_d;
            t_out_q  <= t_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign f7_pos = f7_pos_q;
    assign f7_neg = f7_neg_q;
    assign f8_pos = f8_pos_q;
    assign f8_neg = f8_neg_q;
    assign t_in   = t_in_q;
    assign t_out  = t_out_q;

endmodule

// File: tb/tb_tank_access_sequencer.sv
// Directed bench for tank_access_sequencer: table of word transfers plus abort,
// held-request and mid-transfer reset sequences.
module tb_tank_access_sequencer;
    import edsac_tank_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, digit_tick, req, req_write, abort;
    logic [ADDR_W-1:0] req_addr;
    logic              busy, done, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out;
    logic [4:0]        digit_pos;
    logic [4:0]        minor_pos;

    tank_access_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_tick (digit_tick),
        .req        (req),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .f7_pos     (f7_pos),
        .f7_neg     (f7_neg),
        .f8_pos     (f8_pos),
        .f8_neg     (f8_neg),
        .t_in       (t_in),
        .t_out      (t_out),
        .digit_pos  (digit_pos),
        .minor_pos  (minor_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int mp = 0;
    int dp = 0;
    int wrong_gate = 0;
    int both_hi = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (t_in && t_out) both_hi++;
        if (done) done_cnt++;
    end

    typedef struct {
        logic       wr;
        logic [1:0] tank;
        logic [4:0] word;
        int         acc_m;
        int         acc_d;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock; the bench mirrors the circulation position it drives.
    task automatic step(input logic tk);
        digit_tick = tk;
        @(posedge clk);
        #1;
        digit_tick = 1'b0;
        if (tk) begin
            if (dp == 17) begin
                dp = 0;
                mp = (mp + 1) % 32;
            end else begin
                dp++;
            end
        end
    endtask

    function automatic logic gate_of(input logic wr);
        return wr ? t_in : t_out;
    endfunction

    function automatic int sel_vec();
        return int'({f8_pos, f8_neg, f7_pos, f7_neg});
    endfunction

    function automatic int exp_sel(input logic [1:0] tk);
        logic [3:0] s;
        s = {tk[1], ~tk[1], tk[0], ~tk[0]};
        return int'(s);
    endfunction

    task automatic goto_pos(input int m, input int d, input string tag);
        int guard = 0;
        while (!(mp == m && dp == d) && guard < 1200) begin
            step(1'b1);
            guard++;
        end
        chk({tag, "_pos"}, int'(minor_pos) * 18 + int'(digit_pos), m * 18 + d);
    endtask

    task automatic accept(input logic wr, input logic [1:0] tk, input logic [4:0] wd);
        req       = 1'b1;
        req_write = wr;
        req_addr  = {tk, wd};
        step(1'b0);
        req = 1'b0;
    endtask

    task automatic wait_gate(input logic wr, output int n);
        n = 0;
        while (gate_of(wr) !== 1'b1 && n < 600) begin
            step(1'b1);
            n++;
            if (gate_of(~wr)) wrong_gate++;
        end
    endtask

    task automatic gate_high(input logic wr, output int h);
        h = 0;
        while (gate_of(wr) === 1'b1 && h < 30) begin
            if (done) wrong_gate++;
            step(1'b1);
            h++;
            if (gate_of(~wr)) wrong_gate++;
        end
    endtask

    task automatic do_xfer(input string tag, input logic wr, input logic [1:0] tk,
                           input logic [4:0] wd, input int exp_ticks);
        int n, h;
        accept(wr, tk, wd);
        chk({tag, "_busy_acc"}, int'(busy), 1);
        chk({tag, "_sel"}, sel_vec(), exp_sel(tk));
        wait_gate(wr, n);
        chk({tag, "_wait_ticks"}, n, exp_ticks);
        chk({tag, "_slot_pos"}, int'(minor_pos) * 18 + int'(digit_pos), int'(wd) * 18);
        gate_high(wr, h);
        chk({tag, "_gate_len"}, h, 17);
        chk({tag, "_done_dig"}, int'({done, digit_pos}), 32 + 17);
        step(1'b0);
        chk({tag, "_idle"}, int'({busy, done}) * 16 + sel_vec(), 0);
    endtask

    initial begin
        int n, h, dc;
        rst_n = 1'b0; digit_tick = 1'b0; req = 1'b0; req_write = 1'b0;
        req_addr = '0; abort = 1'b0;

        vecs[0] = '{wr: 1'b0, tank: 2'd2, word: 5'd5,  acc_m: 3,  acc_d: 0,  exp_ticks: 36};
        vecs[1] = '{wr: 1'b1, tank: 2'd1, word: 5'd4,  acc_m: 4,  acc_d: 1,  exp_ticks: 575};
        vecs[2] = '{wr: 1'b0, tank: 2'd3, word: 5'd7,  acc_m: 6,  acc_d: 17, exp_ticks: 1};
        vecs[3] = '{wr: 1'b1, tank: 2'd0, word: 5'd0,  acc_m: 31, acc_d: 5,  exp_ticks: 13};
        vecs[4] = '{wr: 1'b0, tank: 2'd1, word: 5'd20, acc_m: 20, acc_d: 0,  exp_ticks: 576};
        vecs[5] = '{wr: 1'b1, tank: 2'd2, word: 5'd31, acc_m: 10, acc_d: 3,  exp_ticks: 375};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            int'({busy, done, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, digit_pos, minor_pos}), 0);
        rst_n = 1'b1;
        mp = 0;
        dp = 0;
        step(1'b1);
        chk("first_tick_digit", int'(digit_pos), 1);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            goto_pos(vecs[i].acc_m, vecs[i].acc_d, tag);
            do_xfer(tag, vecs[i].wr, vecs[i].tank, vecs[i].word, vecs[i].exp_ticks);
        end

        // Abort mid-transfer, tick-less hold, and abort in WAIT_SLOT.
        goto_pos(1, 0, "ab");
        dc = done_cnt;
        accept(1'b0, 2'd0, 5'd2);
        wait_gate(1'b0, n);
        chk("ab_wait_ticks", n, 18);
        repeat (8) step(1'b1);
        repeat (3) step(1'b0);
        chk("ab_hold", int'({t_out, digit_pos}), 32 + 8);
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("ab_drop", int'({t_out, busy}) * 16 + sel_vec(), 0);
        accept(1'b1, 2'd3, 5'd9);
        chk("ab_reaccept", int'(busy), 1);
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("ab_wait_abort", int'(busy), 0);
        abort = 1'b1;
        accept(1'b1, 2'd3, 5'd9);
        abort = 1'b0;
        chk("ab_req_wins", int'(busy), 1);
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("ab_clear", int'(busy), 0);
        step(1'b0);
        chk("ab_no_done", done_cnt - dc, 0);

        // Held request: address changes while busy are ignored until the next accept.
        req = 1'b1; req_write = 1'b0; req_addr = {2'd1, 5'd3};
        step(1'b0);
        chk("hold_acc1", int'(busy), 1);
        req_write = 1'b1; req_addr = {2'd2, 5'd9};
        wait_gate(1'b0, n);
        chk("hold_slot1", int'(minor_pos) * 18 + int'(digit_pos), 3 * 18);
        chk("hold_sel1", sel_vec(), exp_sel(2'd1));
        gate_high(1'b0, h);
        chk("hold_len1", h, 17);
        chk("hold_done1", int'(done), 1);
        step(1'b0);
        chk("hold_gap", int'({busy, done}), 0);
        step(1'b0);
        req = 1'b0;
        chk("hold_acc2", int'(busy) * 16 + sel_vec(), 16 + exp_sel(2'd2));
        wait_gate(1'b1, n);
        chk("hold_slot2", int'(minor_pos) * 18 + int'(digit_pos), 9 * 18);
        gate_high(1'b1, h);
        chk("hold_len2", h, 17);
        step(1'b0);

        // Asynchronous reset in the middle of a transfer.
        goto_pos(11, 5, "rst");
        accept(1'b0, 2'd3, 5'd12);
        wait_gate(1'b0, n);
        repeat (4) step(1'b1);
        chk("rst_pre", int'({t_out, digit_pos}), 32 + 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            int'({busy, done, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, digit_pos, minor_pos}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mp = 0;
        dp = 0;
        step(1'b0);
        chk("rst_after",
            int'({busy, done, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, digit_pos, minor_pos}), 0);

        chk("wrong_gate", wrong_gate, 0);
        chk("both_gates", both_hi, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
